// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifetch_pkg;

  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 32;
  localparam int INSTR_STEP = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    HOLD    = 3'd2,
    MEM_REQ = 3'd3,
    REFILL  = 3'd4
  } state_t;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, looks up the I-cache, refills misses from memory.
// Latency: hit delivers IC_LAT cycles after lookup starts; miss adds memory wait + refill + re-lookup.
// Backpressure: instruction held in HOLD until instr_ready; redirects abort lookups or wait in pending.
//
// Ports:
//   CLK, RST                   clock and synchronous active-high reset
//   ic_read_en/ic_read_addr    cache lookup request; ic_miss/ic_rdata sampled on the last lookup cycle
//   ic_fetch/ic_write_*        one-cycle cache refill write
//   mem_req/mem_addr           memory word read, completed by mem_ack with mem_rdata
//   instr_valid/instr_ready    decode handshake carrying instr_out/instr_pc
//   redirect_valid/redirect_pc branch redirect from execute
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 20'h00000,
  parameter int                IC_LAT   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              ic_read_en,
  output logic              ic_fetch,
  output logic [ADDR_W-1:0] ic_read_addr,
  output logic [ADDR_W-1:0] ic_write_addr,
  output logic [DATA_W-1:0] ic_write_data,
  input  logic              ic_miss,
  input  logic [DATA_W-1:0] ic_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int              CNT_W    = $clog2(IC_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IC_LAT - 1);

  state_t              r_state,   w_state_nxt;
  logic [ADDR_W-1:0]   r_pc,      w_pc_nxt;
  logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
  logic                r_pend_vld, w_pend_vld_nxt;
  logic [ADDR_W-1:0]   r_pend_pc, w_pend_pc_nxt;
  logic [DATA_W-1:0]   r_instr,   w_instr_nxt;
  logic [ADDR_W-1:0]   r_instr_pc, w_instr_pc_nxt;
  logic [DATA_W-1:0]   r_mem_data, w_mem_data_nxt;

  logic [ADDR_W-1:0]   w_redir_pc;
  logic                w_lookup_done;

  // Targets are always word aligned; the low two bits from execute are dropped.
  assign w_redir_pc    = redirect_pc & ~ADDR_W'(3);
  assign w_lookup_done = (r_cnt == CNT_LAST);

  assign instr_out = r_instr;
  assign instr_pc  = r_instr_pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_cnt      <= '0;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_mem_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_mem_data <= w_mem_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_cnt_nxt      = r_cnt;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_pc_nxt  = r_pend_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_mem_data_nxt = r_mem_data;
    ic_read_en     = 1'b0;
    ic_read_addr   = '0;
    ic_fetch       = 1'b0;
    ic_write_addr  = '0;
    ic_write_data  = '0;
    mem_req        = 1'b0;
    mem_addr       = '0;
    instr_valid    = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = LOOKUP;
      end

      LOOKUP: begin
        ic_read_en   = 1'b1;
        ic_read_addr = r_pc;
        if (redirect_valid) begin
          // Abandon the in-flight lookup and restart the latency count at the target.
          w_pc_nxt    = w_redir_pc;
          w_cnt_nxt   = '0;
          w_state_nxt = LOOKUP;
        end else if (w_lookup_done) begin
          w_cnt_nxt = '0;
          if (!ic_miss) begin
            w_instr_nxt    = ic_rdata;
            w_instr_pc_nxt = r_pc;
            w_state_nxt    = HOLD;
          end else begin
            w_state_nxt = MEM_REQ;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      HOLD: begin
        instr_valid = 1'b1;
        // A redirect wins over a same-cycle handshake: the held word is dropped, not consumed.
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_cnt_nxt   = '0;
          w_state_nxt = LOOKUP;
        end else if (instr_ready) begin
          w_pc_nxt    = r_pc + ADDR_W'(INSTR_STEP);
          w_cnt_nxt   = '0;
          w_state_nxt = LOOKUP;
        end
      end

      MEM_REQ: begin
        mem_req  = 1'b1;
        mem_addr = r_pc;
        // The memory read for the old PC must finish, so redirects are parked until the refill.
        if (redirect_valid) begin
          w_pend_vld_nxt = 1'b1;
          w_pend_pc_nxt  = w_redir_pc;
        end
        if (mem_ack) begin
          w_mem_data_nxt = mem_rdata;
          w_state_nxt    = REFILL;
        end
      end

      REFILL: begin
        ic_fetch      = 1'b1;
        ic_write_addr = r_pc;
        ic_write_data = r_mem_data;
        w_cnt_nxt     = '0;
        w_state_nxt   = LOOKUP;
        // A redirect arriving on this last cycle is the newest one and takes effect directly.
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end else if (r_pend_vld) begin
          w_pc_nxt = r_pend_pc;
        end
        w_pend_vld_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: cache/memory/decode environment models plus a
// transaction-level PC model (next PC = last redirect target, else accepted PC + 4).
// Directed test-plan sequences first, then a randomized run, then a mid-transaction reset.
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  localparam int          IC_LAT   = 2;
  localparam logic [19:0] RESET_PC = 20'h00000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ic_read_en, ic_fetch;
  logic [19:0] ic_read_addr, ic_write_addr;
  logic [31:0] ic_write_data;
  logic        ic_miss;
  logic [31:0] ic_rdata;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out;
  logic [19:0] instr_pc;
  logic        redirect_valid;
  logic [19:0] redirect_pc;

  always #5 CLK = ~CLK;

  ifetch_ctrl #(.RESET_PC(RESET_PC), .IC_LAT(IC_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .ic_read_en(ic_read_en), .ic_fetch(ic_fetch),
    .ic_read_addr(ic_read_addr), .ic_write_addr(ic_write_addr), .ic_write_data(ic_write_data),
    .ic_miss(ic_miss), .ic_rdata(ic_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  bit absent [logic [17:0]];   // words not present in the cache model
  logic [19:0] exp_pc;
  bit          prev_valid, prev_rd, prev_redir, prev_rst, prev_mreq;
  logic [19:0] prev_rd_addr, prev_maddr;
  int          age, mreq_age, ack_dly;
  bit          refill_exp;
  logic [19:0] refill_addr, last_refill_addr;
  int          n_refill, excl_viol;
  bit          new_dlv;
  int          dlv_cyc, prev_dlv_cyc, n_dlv;
  int          ready_mode;     // 0 high, 1 low, 2 random
  bit          redir_arm, rand_mode;
  logic [19:0] redir_tgt;

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    if (a == 20'h00010) return 32'h00B70113;
    return {12'h000, a} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [19:0] rand_tgt();
    if ($urandom_range(0, 7) == 0) return 20'hFFFF0 + 20'($urandom_range(0, 15));
    return 20'h00400 + 20'($urandom_range(0, 1023));
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs just after the edge, then drive this cycle's inputs.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (ic_read_en && ic_fetch) excl_viol++;
    if (RST) begin
      check("rst_outs_zero", 32'(|{ic_read_en, ic_fetch, ic_read_addr, ic_write_addr, ic_write_data,
                                   mem_req, mem_addr, instr_valid, instr_out, instr_pc}), 32'h0);
    end

    new_dlv = instr_valid && !prev_valid;
    if (new_dlv) begin
      prev_dlv_cyc = dlv_cyc;
      dlv_cyc      = cyc;
      n_dlv++;
    end
    if (instr_valid) begin
      check("instr_pc", 32'(instr_pc), 32'(exp_pc));
      check("instr_out", instr_out, mem_word(exp_pc));
    end

    if (refill_exp || ic_fetch) begin
      check("ic_fetch", 32'(ic_fetch), 32'(refill_exp));
      if (refill_exp && ic_fetch) begin
        check("wr_addr", 32'(ic_write_addr), 32'(refill_addr));
        check("wr_data", ic_write_data, mem_word(refill_addr));
        absent.delete(refill_addr[19:2]);
        n_refill++;
        last_refill_addr = ic_write_addr;
      end
      refill_exp = 1'b0;
    end

    // Cache: real answer only on the last lookup cycle, noise otherwise.
    if (ic_read_en && prev_rd && !prev_redir && !prev_rst && ic_read_addr == prev_rd_addr) age++;
    else age = 0;
    if (ic_read_en && age == IC_LAT - 1) begin
      ic_miss  = (absent.exists(ic_read_addr[19:2]) != 0);
      ic_rdata = ic_miss ? $urandom : mem_word(ic_read_addr);
    end else begin
      ic_miss  = 1'($urandom_range(0, 1));
      ic_rdata = $urandom;
    end

    // Memory: ack after ack_dly cycles of mem_req; stray acks with junk data elsewhere.
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req && !RST) begin
      if (!prev_mreq) begin
        mreq_age = 0;
        if (rand_mode) ack_dly = $urandom_range(0, 5);
        check("mreq_on_miss", 32'(absent.exists(mem_addr[19:2]) != 0), 32'h1);
      end else begin
        mreq_age++;
        check("mreq_addr_hold", 32'(mem_addr), 32'(prev_maddr));
      end
      if (mreq_age == ack_dly) begin
        mem_ack     = 1'b1;
        mem_rdata   = mem_word(mem_addr);
        refill_exp  = 1'b1;
        refill_addr = mem_addr;
      end
    end else if ($urandom_range(0, 9) == 0) begin
      mem_ack = 1'b1;
    end

    case (ready_mode)
      0:       instr_ready = 1'b1;
      1:       instr_ready = 1'b0;
      default: instr_ready = ($urandom_range(0, 99) < 70);
    endcase
    if (redir_arm) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt;
      redir_arm      = 1'b0;
    end else if (rand_mode && !RST && $urandom_range(0, 99) < 3) begin
      redirect_valid = 1'b1;
      redirect_pc    = rand_tgt();
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = 20'($urandom);
    end

    // Reference PC for the next delivered instruction.
    if (RST)                              exp_pc = RESET_PC;
    else if (redirect_valid)              exp_pc = redirect_pc & 20'hFFFFC;
    else if (instr_valid && instr_ready)  exp_pc = exp_pc + 20'd4;

    prev_valid   = instr_valid;
    prev_rd      = ic_read_en;
    prev_rd_addr = ic_read_addr;
    prev_redir   = redirect_valid;
    prev_rst     = RST;
    prev_mreq    = mem_req && !RST;
    prev_maddr   = mem_addr;
  endtask

  task automatic wait_dlv(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!new_dlv && n < budget);
    check(tag, 32'(new_dlv), 32'h1);
  endtask

  task automatic wait_mreq(input logic [19:0] a, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(mem_req && mem_addr == a) && n < budget);
    check("mreq_seen", 32'(mem_req && mem_addr == a), 32'h1);
  endtask

  initial begin
    bit rd_seen;
    int refills_before;
    RST = 1'b1;
    ic_miss = 1'b0; ic_rdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ready_mode = 0; redir_arm = 1'b0; rand_mode = 1'b0; ack_dly = 4;
    exp_pc = RESET_PC; n_refill = 0; excl_viol = 0; n_dlv = 0;
    dlv_cyc = 0; prev_dlv_cyc = 0; refill_exp = 1'b0;
    absent[18'h00004] = 1'b1;   // 0x00010
    absent[18'h00040] = 1'b1;   // 0x00100

    repeat (3) step();
    RST = 1'b0;

    // Hits with ready high: 0, 4, 8 at IC_LAT+1 spacing.
    wait_dlv("dlv_pc0", 20);
    check("pc0", 32'(instr_pc), 32'h0);
    check("pc0_data", instr_out, 32'hA5A5_0000);
    step();
    check("valid_falls", 32'(instr_valid), 32'h0);
    wait_dlv("dlv_pc4", 20);
    check("pc4", 32'(instr_pc), 32'h4);
    check("gap_hit", 32'(dlv_cyc - prev_dlv_cyc), 32'(IC_LAT + 1));
    wait_dlv("dlv_pc8", 20);
    check("pc8", 32'(instr_pc), 32'h8);
    check("gap_hit2", 32'(dlv_cyc - prev_dlv_cyc), 32'(IC_LAT + 1));
    wait_dlv("dlv_pcc", 20);

    // Miss at 0x10 with the memory answering 4 cycles after mem_req.
    wait_dlv("dlv_pc10", 40);
    check("pc10", 32'(instr_pc), 32'h10);
    check("pc10_data", instr_out, 32'h00B70113);
    check("gap_miss", 32'(dlv_cyc - prev_dlv_cyc), 32'(1 + IC_LAT + (4 + 1) + 1 + IC_LAT));
    check("refill_cnt1", 32'(n_refill), 32'd1);
    check("refill_addr1", 32'(last_refill_addr), 32'h10);

    // Decode backpressure.
    ready_mode = 1;
    wait_dlv("dlv_pc14", 20);
    rd_seen = 1'b0;
    repeat (5) begin
      step();
      rd_seen |= ic_read_en;
    end
    check("bp_no_lookup", 32'(rd_seen), 32'h0);
    check("bp_valid", 32'(instr_valid), 32'h1);
    check("bp_pc", 32'(instr_pc), 32'h14);
    ready_mode = 0;
    step();
    ready_mode = 1;
    wait_dlv("dlv_pc18", 20);
    check("pc18", 32'(instr_pc), 32'h18);

    // Redirect coincident with a handshake.
    redir_tgt = 20'h00103; redir_arm = 1'b1; ready_mode = 0;
    step();
    step();
    check("redir_drop", 32'(instr_valid), 32'h0);

    // Two redirects while the 0x100 miss is at memory.
    wait_mreq(20'h00100, 20);
    redir_tgt = 20'h00200; redir_arm = 1'b1;
    step();
    redir_tgt = 20'h00300; redir_arm = 1'b1;
    step();
    wait_dlv("dlv_pc300", 40);
    check("pc300", 32'(instr_pc), 32'h300);
    check("refill_cnt2", 32'(n_refill), 32'd2);
    check("refill_addr2", 32'(last_refill_addr), 32'h100);

    // PC wrap.
    ready_mode = 1; redir_tgt = 20'hFFFFE; redir_arm = 1'b1;
    step();
    ready_mode = 0;
    wait_dlv("dlv_wrap", 20);
    check("pc_fffc", 32'(instr_pc), 32'hFFFFC);
    wait_dlv("dlv_wrap0", 20);
    check("pc_wrap0", 32'(instr_pc), 32'h0);

    // Randomized run.
    for (int a = 'h400; a < 'h800; a += 4)
      if ($urandom_range(0, 3) == 0) absent[18'(a >> 2)] = 1'b1;
    for (int a = 'hFFF00; a < 'h100000; a += 4)
      if ($urandom_range(0, 3) == 0) absent[18'(a >> 2)] = 1'b1;
    n_dlv = 0;
    rand_mode = 1'b1; ready_mode = 2;
    repeat (4000) step();
    rand_mode = 1'b0; ready_mode = 0;
    check("rand_progress", 32'(n_dlv > 100), 32'h1);

    // Reset in the middle of a memory transaction.
    absent[18'h00200] = 1'b1;   // 0x00800
    ack_dly = 50;
    redir_tgt = 20'h00800; redir_arm = 1'b1;
    step();
    wait_mreq(20'h00800, 200);
    refills_before = n_refill;
    RST = 1'b1;
    step();
    check("rst_mreq_drop", 32'(mem_req), 32'h0);
    repeat (3) step();
    RST = 1'b0;
    ack_dly = 2;
    wait_dlv("dlv_after_rst", 20);
    check("pc_after_rst", 32'(instr_pc), 32'(RESET_PC));
    check("no_refill_rst", 32'(n_refill), 32'(refills_before));
    wait_dlv("dlv_after_rst2", 20);
    check("pc_after_rst2", 32'(instr_pc), 32'(RESET_PC + 20'd4));

    check("rd_fetch_excl", 32'(excl_viol), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction fetch controller sitting directly upstream of the 4-way instruction cache. It owns the program counter, drives cache lookups, and on a cache miss fetches the missing 32-bit word from main memory, writes it into the cache, and retries the lookup. Fetched instructions go to decode over a valid/ready handshake, and branch redirects from execute are accepted at any time.

## Interface
Parameters:
- RESET_PC, 20'h00000: PC value loaded on reset; bits [1:0] must be 0.
- IC_LAT, 2: cycles from first ic_read_en cycle to the edge at which ic_miss/ic_rdata are valid; legal range 1..7.

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- ic_read_en  out  1  cache read request.
- ic_fetch  out  1  cache refill write strobe.
- ic_read_addr  out  20  lookup byte address.
- ic_write_addr  out  20  refill byte address.
- ic_write_data  out  32  refill word.
- ic_miss  in  1  cache miss flag, valid at sample edge.
- ic_rdata  in  32  cache hit data, valid at sample edge.
- mem_req  out  1  memory read request.
- mem_addr  out  20  memory word address (byte address, [1:0]=0).
- mem_ack  in  1  memory data valid this cycle.
- mem_rdata  in  32  memory read word.
- instr_valid  out  1  instr_out/instr_pc valid to decode.
- instr_ready  in  1  decode accepts.
- instr_out  out  32  instruction word.
- instr_pc  out  20  address of instr_out.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  20  redirect target; [1:0] forced to 0 internally.

## Operation
- States: IDLE, LOOKUP, HOLD, MEM_REQ, REFILL.
- RST=1: state IDLE, pc=RESET_PC, lookup counter=0, pending-redirect cleared; every output 0.
- IDLE → LOOKUP unconditionally.
- LOOKUP: ic_read_en=1, ic_read_addr=pc held stable for IC_LAT cycles. At the end of the last cycle, sample ic_miss:
  - If ic_miss=0, register ic_rdata into instr_out and pc into instr_pc, then go to HOLD.
  - If ic_miss=1, go to MEM_REQ.
- HOLD: instr_valid=1, instr_out/instr_pc stable. On instr_ready=1, pc←pc+4 and go to LOOKUP.
- MEM_REQ: mem_req=1, mem_addr=pc held until mem_ack. mem_ack may arrive in the same cycle mem_req first rises. On ack, latch mem_rdata and go to REFILL.
- REFILL: exactly one cycle with ic_fetch=1, ic_write_addr=pc, ic_write_data=latched word. Then go to LOOKUP at the same pc; the re-lookup is expected to hit.
- ic_read_en and ic_fetch are never both 1.
- Redirect in LOOKUP or HOLD: pc←redirect_pc&~3, counter←0, go to LOOKUP. Any held instruction is discarded. Redirect beats an instr_ready handshake in the same cycle, so that instruction is not consumed.
- Redirect in MEM_REQ or REFILL: store it in the pending register; a later redirect overwrites it. The memory transaction and refill for the old pc complete normally. On leaving REFILL, pc←pending value, pending cleared, go to LOOKUP.
- PC arithmetic is 20-bit modulo; 20'hFFFFC+4 wraps to 20'h00000.
- mem_ack outside MEM_REQ is ignored.

## Timing
- Hit latency: LOOKUP entered in cycle 0 → instr_valid=1 in cycle IC_LAT.
- Back-to-back hits with instr_ready tied high: one instruction per IC_LAT+1 cycles.
- Miss cost: IC_LAT (miss lookup) + memory wait (≥1 cycle) + 1 (REFILL) + IC_LAT (re-lookup) + 1 cycles to instr_valid.
- instr_valid falls in the cycle after the handshake or redirect.
- Reset asserted mid-transaction: mem_req drops the next cycle, and any following mem_ack is ignored.

## Structure
- Package ifetch_pkg: state enum (IDLE, LOOKUP, HOLD, MEM_REQ, REFILL), ADDR_W=20, DATA_W=32, INSTR_STEP=4.
- Single module, no sub-modules; the lookup counter is $clog2(IC_LAT+1) bits wide.

## Test plan
- Reset then all hits (cache model returns ic_rdata=pc^32'hA5A5_0000, ic_miss=0), IC_LAT=2, ready high → instr_pc 0,4,8 with instr_valid every 3rd cycle; outputs 0 during RST.
- Miss at pc=20'h00010, mem_ack 4 cycles after mem_req with 32'h00B70113 → one ic_fetch pulse with write_addr 20'h00010, data 32'h00B70113; re-lookup hit; instr_out=32'h00B70113.
- Decode backpressure: ready low 5 cycles in HOLD → instr_out/instr_pc stable, no new ic_read_en; ready high → pc advances by 4.
- Redirect to 20'h00103 coincident with a ready handshake in HOLD → pc=20'h00100, held instruction dropped, next instr_pc=20'h00100.
- Two redirects (20'h00200, then 20'h00300) during MEM_REQ → refill completes for the old pc, next lookup at 20'h00300.
- pc=20'hFFFFC accepted → next lookup at 20'h00000; assert ic_read_en&ic_fetch never 1 across all tests.
